// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths, entry types and pointer-wrap helper for the reorder buffer
package reorder_buffer_pkg;
    localparam int ROB_ID_W = 5;
    localparam int XLEN = 32;
    localparam int ROB_N = 1 << ROB_ID_W;
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [ROB_ID_W:0] cnt_t;
    localparam rob_id_t NULL_ROB_ID = '0;
    typedef enum logic [1:0] {ROB_REG = 2'b00, ROB_BRANCH = 2'b01, ROB_STORE = 2'b10} rob_type_e;
    typedef struct packed {
        logic busy;
        logic ready;
        rob_type_e kind;
        logic [4:0] rd;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] pred_pc;
        logic [XLEN-1:0] next_pc;
    } rob_entry_t;
    // Id 0 means "no dependency", so the pointer skips it on wrap.
    function automatic rob_id_t ptr_inc(input rob_id_t p);
        return (p == rob_id_t'(ROB_N - 1)) ? rob_id_t'(1) : p + rob_id_t'(1);
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: decoder, CDB, forwarding, launch and commit signals of the reorder buffer
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;
    logic _dec_ready;
    logic [1:0] _dec_type;
    logic [4:0] _dec_rd;
    logic [XLEN-1:0] _dec_pred_pc;
    logic _rob_full;
    logic _rob_launch_ready;
    rob_id_t _rob_launch_rob_id;
    logic [4:0] _rob_launch_register_id;
    logic _cdb_ready;
    rob_id_t _cdb_rob_id;
    logic [XLEN-1:0] _cdb_value;
    logic [XLEN-1:0] _cdb_next_pc;
    rob_id_t _ask_id_1, _ask_id_2;
    logic _ask_ready_1, _ask_ready_2;
    logic [XLEN-1:0] _ask_value_1, _ask_value_2;
    logic _rob_commit_ready;
    rob_id_t _rob_commit_rob_id;
    logic [4:0] _rob_commit_register_id;
    logic [XLEN-1:0] _rob_commit_value;
    logic _rob_commit_store;
    logic _clear;
    logic [XLEN-1:0] _clear_pc;
    modport master (
        output _dec_ready, _dec_type, _dec_rd, _dec_pred_pc, _cdb_ready, _cdb_rob_id, _cdb_value,
               _cdb_next_pc, _ask_id_1, _ask_id_2,
        input  _rob_full, _rob_launch_ready, _rob_launch_rob_id, _rob_launch_register_id,
               _ask_ready_1, _ask_ready_2, _ask_value_1, _ask_value_2, _rob_commit_ready,
               _rob_commit_rob_id, _rob_commit_register_id, _rob_commit_value, _rob_commit_store,
               _clear, _clear_pc
    );
    modport slave (
        input  _dec_ready, _dec_type, _dec_rd, _dec_pred_pc, _cdb_ready, _cdb_rob_id, _cdb_value,
               _cdb_next_pc, _ask_id_1, _ask_id_2,
        output _rob_full, _rob_launch_ready, _rob_launch_rob_id, _rob_launch_register_id,
               _ask_ready_1, _ask_ready_2, _ask_value_1, _ask_value_2, _rob_commit_ready,
               _rob_commit_rob_id, _rob_commit_register_id, _rob_commit_value, _rob_commit_store,
               _clear, _clear_pc
    );
endinterface

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail/count bookkeeping with 1..31 wrap and full flag
module rob_ptr_ctrl import reorder_buffer_pkg::*; (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic launch,
    input  logic commit,
    input  logic flush,
    output rob_id_t head,
    output rob_id_t tail,
    output cnt_t count,
    output logic full
);
    rob_id_t head_q, head_d, tail_q, tail_d;
    cnt_t count_q, count_d;
    always_comb begin
        head_d = flush ? rob_id_t'(1) : commit ? ptr_inc(head_q) : head_q;
        tail_d = flush ? rob_id_t'(1) : launch ? ptr_inc(tail_q) : tail_q;
        count_d = flush ? '0 : count_q + cnt_t'(launch) - cnt_t'(commit);
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q <= rob_id_t'(1);
            tail_q <= rob_id_t'(1);
            count_q <= '0;
        end else if (rdy_in) begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end
    assign head = head_q;
    assign tail = tail_q;
    assign count = count_q;
    assign full = count_q == cnt_t'(ROB_N - 1);
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with CDB capture, operand forwarding and mispredict flush
module reorder_buffer import reorder_buffer_pkg::*; (
    input logic clk_in,
    input logic rst_in,
    input logic rdy_in,
    reorder_buffer_if.slave bus
);
    rob_entry_t entry_q [ROB_N];
    rob_entry_t entry_d [ROB_N];
    rob_entry_t h;
    rob_id_t head, tail;
    cnt_t count;
    logic full, launch, cdb_we, commit, mispredict;
    logic commit_ready_q, commit_ready_d, commit_store_q, commit_store_d, clear_q, clear_d;
    rob_id_t commit_rob_id_q, commit_rob_id_d;
    logic [4:0] commit_rd_q, commit_rd_d;
    logic [XLEN-1:0] commit_value_q, commit_value_d, clear_pc_q, clear_pc_d;
    logic cdb_hit_1, cdb_hit_2;
    rob_ptr_ctrl u_ptr (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .launch(launch), .commit(commit),
        .flush(mispredict), .head(head), .tail(tail), .count(count), .full(full)
    );
    // The clear cycle blocks all three pipelines so nothing from the flushed path sticks.
    always_comb begin
        h = entry_q[head];
        launch = bus._dec_ready && !full && !clear_q;
        cdb_we = bus._cdb_ready && !clear_q && entry_q[bus._cdb_rob_id].busy;
        commit = !clear_q && count != '0 && h.ready;
        mispredict = commit && h.kind == ROB_BRANCH && h.next_pc != h.pred_pc;
        entry_d = entry_q;
        if (launch)
            entry_d[tail] = '{busy: 1'b1, ready: 1'b0, kind: rob_type_e'(bus._dec_type), rd: bus._dec_rd,
                              value: '0, pred_pc: bus._dec_pred_pc, next_pc: '0};
        if (cdb_we) begin
            entry_d[bus._cdb_rob_id].ready = 1'b1;
            entry_d[bus._cdb_rob_id].value = bus._cdb_value;
            entry_d[bus._cdb_rob_id].next_pc = bus._cdb_next_pc;
        end
        if (commit) begin
            entry_d[head].busy = 1'b0;
            entry_d[head].ready = 1'b0;
        end
        if (mispredict)
            for (int i = 0; i < ROB_N; i++) begin
                entry_d[i].busy = 1'b0;
                entry_d[i].ready = 1'b0;
            end
        commit_ready_d = commit;
        commit_rob_id_d = commit ? head : commit_rob_id_q;
        commit_rd_d = commit ? (h.kind == ROB_STORE ? 5'd0 : h.rd) : commit_rd_q;
        commit_value_d = commit ? h.value : commit_value_q;
        commit_store_d = commit ? h.kind == ROB_STORE : commit_store_q;
        clear_d = mispredict;
        clear_pc_d = mispredict ? h.next_pc : clear_pc_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_N; i++) entry_q[i] <= '0;
            commit_ready_q <= 1'b0;
            commit_rob_id_q <= '0;
            commit_rd_q <= '0;
            commit_value_q <= '0;
            commit_store_q <= 1'b0;
            clear_q <= 1'b0;
            clear_pc_q <= '0;
        end else if (rdy_in) begin
            entry_q <= entry_d;
            commit_ready_q <= commit_ready_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_rd_q <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_store_q <= commit_store_d;
            clear_q <= clear_d;
            clear_pc_q <= clear_pc_d;
        end
    end
    always_comb begin
        cdb_hit_1 = bus._cdb_ready && bus._cdb_rob_id == bus._ask_id_1;
        cdb_hit_2 = bus._cdb_ready && bus._cdb_rob_id == bus._ask_id_2;
    end
    assign bus._ask_ready_1 = bus._ask_id_1 != NULL_ROB_ID && (cdb_hit_1 || entry_q[bus._ask_id_1].ready);
    assign bus._ask_ready_2 = bus._ask_id_2 != NULL_ROB_ID && (cdb_hit_2 || entry_q[bus._ask_id_2].ready);
    assign bus._ask_value_1 = cdb_hit_1 ? bus._cdb_value : entry_q[bus._ask_id_1].value;
    assign bus._ask_value_2 = cdb_hit_2 ? bus._cdb_value : entry_q[bus._ask_id_2].value;
    assign bus._rob_full = full;
    assign bus._rob_launch_ready = launch;
    assign bus._rob_launch_rob_id = tail;
    assign bus._rob_launch_register_id = bus._dec_rd;
    assign bus._rob_commit_ready = commit_ready_q;
    assign bus._rob_commit_rob_id = commit_rob_id_q;
    assign bus._rob_commit_register_id = commit_rd_q;
    assign bus._rob_commit_value = commit_value_q;
    assign bus._rob_commit_store = commit_store_q;
    assign bus._clear = clear_q;
    assign bus._clear_pc = clear_pc_q;
endmodule
